// File: rtl/axil_ram_rd.sv
// AXI4-lite read-only RAM slave: word-organised synchronous RAM, sideband byte-strobed
// load port, SLVERR for addresses above the implemented range, optional R output stage.
module axil_ram_rd #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 16,
    parameter int STRB_WIDTH       = DATA_WIDTH/8,
    parameter int VALID_ADDR_WIDTH = 12,
    parameter int PIPELINE_OUTPUT  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       s_axil_araddr,
    input  logic [2:0]                  s_axil_arprot,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [DATA_WIDTH-1:0]       s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    input  logic                        ld_en,
    input  logic [VALID_ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]       ld_data,
    input  logic [STRB_WIDTH-1:0]       ld_strb
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = VALID_ADDR_WIDTH - ADDR_LSB;
    localparam int DEPTH    = 2**IDX_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rd_q;

    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      ld_idx;
    logic                  in_range;
    logic                  ar_hs;
    logic                  s1_adv;
    logic                  s1_drain;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_err_q, s1_err_d;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [1:0]            s1_resp;

    logic                  unused_ok;

    assign unused_ok = ^{s_axil_arprot, s_axil_araddr, ld_addr};

    assign rd_idx = s_axil_araddr[VALID_ADDR_WIDTH-1:ADDR_LSB];
    assign ld_idx = ld_addr[VALID_ADDR_WIDTH-1:ADDR_LSB];

    generate
        if (VALID_ADDR_WIDTH < ADDR_WIDTH) begin : g_range
            assign in_range = ~|s_axil_araddr[ADDR_WIDTH-1:VALID_ADDR_WIDTH];
        end else begin : g_full_range
            assign in_range = 1'b1;
        end
    endgenerate

    // s1 can take a new request whenever it is empty or hands its beat on this cycle.
    assign s1_drain       = s1_valid_q && s1_adv;
    assign s_axil_arready = !rst && (!s1_valid_q || s1_adv);
    assign ar_hs          = s_axil_arvalid && s_axil_arready;

    // Read-before-write: a same-cycle load and read of one word returns the old contents.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (ld_strb[b]) mem[ld_idx][b*8 +: 8] <= ld_data[b*8 +: 8];
            end
        end
        if (ar_hs && in_range) ram_rd_q <= mem[rd_idx];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_err_d   = s1_err_q;
        if (ar_hs) begin
            s1_valid_d = 1'b1;
            s1_err_d   = !in_range;
        end else if (s1_drain) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
        end
    end

    // The RAM output register is not reset, so idle and error slots are forced to zero here.
    assign s1_data = (s1_valid_q && !s1_err_q) ? ram_rd_q : '0;
    assign s1_resp = (s1_valid_q && s1_err_q) ? 2'b10 : 2'b00;

    generate
        if (PIPELINE_OUTPUT != 0) begin : g_pipe
            logic                  s2_valid_q;
            logic [DATA_WIDTH-1:0] s2_data_q;
            logic [1:0]            s2_resp_q;

            assign s1_adv = !s2_valid_q || s_axil_rready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                    s2_resp_q  <= 2'b00;
                end else if (s1_drain) begin
                    s2_valid_q <= 1'b1;
                    s2_data_q  <= s1_data;
                    s2_resp_q  <= s1_resp;
                end else if (s_axil_rready) begin
                    s2_valid_q <= 1'b0;
                end
            end

            assign s_axil_rvalid = s2_valid_q;
            assign s_axil_rdata  = s2_data_q;
            assign s_axil_rresp  = s2_resp_q;
        end else begin : g_direct
            assign s1_adv        = s_axil_rready;
            assign s_axil_rvalid = s1_valid_q;
            assign s_axil_rdata  = s1_data;
            assign s_axil_rresp  = s1_resp;
        end
    endgenerate

endmodule
